conv_out_collector: RTL and testbench
=====================================

CONV_OUT_COLLECTOR -- requirements
Module: conv_out_collector

Interface
REQ-001 Parameter KERNEL_SIZE, default 3: kernel edge length, equal to the value used by the upstream PE.
REQ-002 Parameter FM_SIZE, default 4: feature-map edge length, with FM_SIZE >= KERNEL_SIZE.
REQ-003 Parameter OUT_WIDTH, default 16: width of the signed output word.
REQ-004 Parameter SHIFT, default 0: arithmetic right-shift applied to each accepted sample, range 0..47.
REQ-005 Parameter FIFO_DEPTH, default 4: output FIFO entries, power of two, at least 2.
REQ-006 i_clk  input  1: single clock; every register updates on its rising edge.
REQ-007 i_rst  input  1: synchronous, active-high reset.
REQ-008 i_en  input  1: sample-valid strobe, driven by the PE o_en.
REQ-009 i_P  input  48 signed: raw accumulator sample, driven by the PE o_P.
REQ-010 o_data  output  OUT_WIDTH signed: head of the output FIFO.
REQ-011 o_valid  output  1: o_data is valid.
REQ-012 i_ready  input  1: downstream accepts o_data.
REQ-013 o_done  output  1: single-cycle pulse marking frame completion.
REQ-014 o_overflow  output  1: sticky flag, set when a sample is dropped.

Function
REQ-015 The block SHALL implement the states IDLE, COLLECT, DRAIN and DONE.
REQ-016 IDLE SHALL go to COLLECT on the first cycle with i_en=1, and that sample SHALL be processed as column 0, row 0.
REQ-017 In IDLE and COLLECT, each cycle with i_en=1 SHALL advance a column counter 0..FM_SIZE-1; on wrap from FM_SIZE-1 the row counter SHALL increment.
REQ-018 A sample SHALL be accepted only when column <= FM_SIZE-KERNEL_SIZE; samples in other columns are row-wrap artifacts and SHALL be discarded silently.
REQ-019 When i_en=0 in COLLECT, the counters SHALL hold (pause) and no sample SHALL be processed.
REQ-020 After (FM_SIZE-KERNEL_SIZE+1)^2 accepted samples, the state SHALL go to DRAIN, and i_en SHALL be ignored until the block returns to IDLE.
REQ-021 DRAIN SHALL go to DONE once the quantize stage and the FIFO are both empty.
REQ-022 DONE SHALL assert o_done for exactly one cycle, clear the counters, and go to IDLE.
REQ-023 Quantization SHALL compute an arithmetic shift of i_P right by SHIFT (floor rounding), then saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-024 The quantize stage SHALL be one registered stage feeding a first-word-fall-through FIFO.
REQ-025 With the FIFO empty, o_valid SHALL rise 2 cycles after the edge that sampled the accepted i_en.
REQ-026 A FIFO word SHALL be popped on each cycle with o_valid=1 and i_ready=1.
REQ-027 o_data SHALL remain stable while o_valid=1 and i_ready=0.
REQ-028 A push into a full FIFO in the same cycle as a pop SHALL succeed.
REQ-029 A push into a full FIFO without a pop SHALL drop the word and set o_overflow.
REQ-030 o_overflow SHALL remain set until reset.
REQ-031 When KERNEL_SIZE == FM_SIZE, exactly one sample (column 0 of row 0) SHALL be accepted per frame.

Reset
REQ-032 i_rst=1 SHALL, at the next edge, set state=IDLE, clear the counters, flush the FIFO and quantize stage, and drive o_valid=0, o_done=0, o_overflow=0, o_data=0.
REQ-033 A reset asserted mid-frame SHALL abandon the frame, and no o_done SHALL be produced for it.
REQ-034 i_en SHALL be ignored in any cycle where i_rst=1.

Configuration
REQ-035 With macro CONV_OUT_RELU_EN defined, negative shifted values SHALL be forced to 0 before saturation.
REQ-036 Without CONV_OUT_RELU_EN, signed values SHALL pass through to saturation unchanged, and no ReLU logic SHALL be synthesized.

Verification
REQ-037 FM=4, K=3, i_P=index 0..15, i_ready=1 -> outputs 0,1,4,5, then o_done one cycle after the FIFO empties.
REQ-038 SHIFT=4, OUT_WIDTH=16, i_P=48'h000000100000 -> o_data=16'h7FFF; i_P=-48'sd1048576 -> o_data=16'h8000.
REQ-039 SHIFT=1, i_P=-5 -> o_data=-3 without CONV_OUT_RELU_EN, and o_data=0 with it.
REQ-040 FIFO_DEPTH=4, i_ready=0, 6 accepted samples -> 4 stored, o_overflow=1, stored values intact on release.
REQ-041 Reset after 7 inputs, then a full new frame -> only the new frame's 4 outputs appear, with exactly one o_done.
REQ-042 FM=K=4, 16 inputs -> one output equal to sample 0, then o_done.

Source files
------------

// File: rtl/conv_out_collector.sv
// Collects PE accumulator samples of one valid-convolution frame, quantizes them and buffers them in an FWFT FIFO.
// Optional ReLU ahead of saturation: define CONV_OUT_RELU_EN.
module conv_out_collector #(
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned FM_SIZE     = 4,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter int unsigned SHIFT       = 0,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_en,
    input  logic signed [47:0]          i_P,
    output logic signed [OUT_WIDTH-1:0] o_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_done,
    output logic                        o_overflow
);
    localparam int unsigned LAST_COL = FM_SIZE - KERNEL_SIZE;
    localparam int unsigned OUTS     = (LAST_COL + 1) * (LAST_COL + 1);
    localparam int unsigned CW       = (FM_SIZE > 1) ? $clog2(FM_SIZE) : 1;
    localparam int unsigned NW       = $clog2(OUTS + 1);
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned DW       = AW + 1;

    localparam logic [CW-1:0]      COL_ACC_MAX = CW'(LAST_COL);
    localparam logic [CW-1:0]      COL_MAX     = CW'(FM_SIZE - 1);
    localparam logic [NW-1:0]      ACC_LAST    = NW'(OUTS - 1);
    localparam logic [DW-1:0]      FULL_CNT    = DW'(FIFO_DEPTH);
    localparam logic signed [47:0] SAT_MAX     = {{(49 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [47:0] SAT_MIN     = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

    state_t                      state;
    logic [CW-1:0]               col;
    logic [CW-1:0]               row;
    logic [NW-1:0]               n_acc;
    logic                        q_valid;
    logic signed [OUT_WIDTH-1:0] q_data;
    logic signed [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic [AW-1:0]               rd_next;
    logic [DW-1:0]               count;
    logic [DW-1:0]               count_left;
    logic                        take;
    logic                        accept;
    logic                        pop;
    logic                        push;
    logic                        drop;
    logic signed [47:0]          shifted;
    logic signed [OUT_WIDTH-1:0] quant;

    // Acceptance, FIFO handshake and quantizer datapath.
    always_comb begin
        take       = i_en && (state == IDLE || state == COLLECT);
        accept     = take && (col <= COL_ACC_MAX);
        pop        = o_valid && i_ready;
        push       = q_valid && ((count != FULL_CNT) || pop);
        drop       = q_valid && (count == FULL_CNT) && !pop;
        count_left = count - DW'(pop);
        rd_next    = rd_ptr + AW'(pop);
        shifted    = i_P >>> SHIFT;
`ifdef CONV_OUT_RELU_EN
        if (shifted[47]) shifted = '0;
`endif
        if (shifted > SAT_MAX)      quant = SAT_MAX[OUT_WIDTH-1:0];
        else if (shifted < SAT_MIN) quant = SAT_MIN[OUT_WIDTH-1:0];
        else                        quant = shifted[OUT_WIDTH-1:0];
    end

    // Head register only reloads from words already stored before this edge, giving two-cycle latency.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            n_acc      <= '0;
            q_valid    <= 1'b0;
            q_data     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_done     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            q_valid <= accept;
            if (accept) q_data <= quant;
            if (push) begin
                mem[wr_ptr] <= q_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (drop) o_overflow <= 1'b1;
            rd_ptr  <= rd_next;
            count   <= count_left + DW'(push);
            o_valid <= (count_left != '0);
            if (count_left != '0) o_data <= mem[rd_next];
            o_done  <= 1'b0;

            case (state)
                IDLE, COLLECT: begin
                    if (take) begin
                        if (col == COL_MAX) begin
                            col <= '0;
                            row <= row + CW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                        state <= COLLECT;
                        if (accept) begin
                            n_acc <= n_acc + NW'(1);
                            if (n_acc == ACC_LAST) state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!q_valid && count == '0) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    col   <= '0;
                    row   <= '0;
                    n_acc <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_out_collector.sv
// Bench for conv_out_collector: three configurations checked every cycle against a frame/queue model,
// plus literal expectations on the popped output streams.
module tb_conv_out_collector;
    localparam int ND = 3;
    localparam int FMV [ND] = '{4, 4, 4};
    localparam int KV  [ND] = '{3, 2, 4};
    localparam int SHV [ND] = '{0, 4, 1};
`ifdef CONV_OUT_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [2:0]          en;
    logic signed [47:0]  p;
    logic                ready;
    logic signed [15:0]  od [ND];
    logic [2:0]          ov;
    logic [2:0]          odn;
    logic [2:0]          oov;

    int checks = 0;
    int errors = 0;

    // Model state
    int now = 0;
    int m_idx [ND];
    int m_nacc [ND];
    int m_phase [ND];
    bit m_s1v [ND];
    int m_s1d [ND];
    int fv [ND][4];
    int ft [ND][4];
    int fh [ND];
    int fc [ND];
    bit e_valid [ND];
    bit e_done [ND];
    bit e_ovf [ND];
    int e_data [ND];

    // Output logs taken from the DUT handshake
    int lg [ND][32];
    int ln [ND];
    int dn [ND];
    int ex [9];

    always #5 clk = ~clk;

    conv_out_collector #(.KERNEL_SIZE(3), .FM_SIZE(4), .OUT_WIDTH(16), .SHIFT(0), .FIFO_DEPTH(4)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_en(en[0]), .i_P(p), .o_data(od[0]), .o_valid(ov[0]),
        .i_ready(ready), .o_done(odn[0]), .o_overflow(oov[0]));
    conv_out_collector #(.KERNEL_SIZE(2), .FM_SIZE(4), .OUT_WIDTH(16), .SHIFT(4), .FIFO_DEPTH(4)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_en(en[1]), .i_P(p), .o_data(od[1]), .o_valid(ov[1]),
        .i_ready(ready), .o_done(odn[1]), .o_overflow(oov[1]));
    conv_out_collector #(.KERNEL_SIZE(4), .FM_SIZE(4), .OUT_WIDTH(16), .SHIFT(1), .FIFO_DEPTH(4)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_en(en[2]), .i_P(p), .o_data(od[2]), .o_valid(ov[2]),
        .i_ready(ready), .o_done(odn[2]), .o_overflow(oov[2]));

    function automatic int qf(input logic signed [47:0] v, input int sh);
        logic signed [47:0] s;
        s = v >>> sh;
        if (RELU && s < 48'sd0) s = 48'sd0;
        if (s > 48'sd32767) return 32767;
        if (s < -48'sd32768) return -32768;
        return int'(s);
    endfunction

    task automatic chk(input string nm, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Frame model: column = sample index mod FM, fixed two-stage latency, FIFO as a time-stamped ring.
    task automatic model_step();
        now++;
        for (int d = 0; d < ND; d++) begin
            bit popm;
            bit full;
            bit drain_done;
            bit acc;
            int n_out;
            popm = e_valid[d] && ready;
            if (rst) begin
                e_valid[d] = 0; e_done[d] = 0; e_ovf[d] = 0; e_data[d] = 0;
                fc[d] = 0; fh[d] = 0; m_s1v[d] = 0; m_phase[d] = 0; m_idx[d] = 0; m_nacc[d] = 0;
            end else begin
                n_out = (FMV[d] - KV[d] + 1) * (FMV[d] - KV[d] + 1);
                full = (fc[d] == 4);
                drain_done = (m_phase[d] == 1) && !m_s1v[d] && (fc[d] == 0);
                if (popm) begin
                    fh[d] = (fh[d] + 1) % 4;
                    fc[d]--;
                end
                if (m_s1v[d]) begin
                    if (!full || popm) begin
                        fv[d][(fh[d] + fc[d]) % 4] = m_s1d[d];
                        ft[d][(fh[d] + fc[d]) % 4] = now;
                        fc[d]++;
                    end else begin
                        e_ovf[d] = 1;
                    end
                end
                acc = (m_phase[d] == 0) && en[d] && ((m_idx[d] % FMV[d]) <= FMV[d] - KV[d]);
                m_s1v[d] = acc;
                m_s1d[d] = qf(p, SHV[d]);
                if (m_phase[d] == 0 && en[d]) begin
                    m_idx[d]++;
                    if (acc) begin
                        m_nacc[d]++;
                        if (m_nacc[d] == n_out) m_phase[d] = 1;
                    end
                end else if (drain_done) begin
                    m_phase[d] = 2;
                end else if (m_phase[d] == 2) begin
                    m_phase[d] = 0; m_idx[d] = 0; m_nacc[d] = 0;
                end
                e_done[d]  = (m_phase[d] == 2);
                e_valid[d] = (fc[d] > 0) && (ft[d][fh[d]] < now);
                if (e_valid[d]) e_data[d] = fv[d][fh[d]];
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison and output logging.
    initial forever begin
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk("valid", d, int'(ov[d]), int'(e_valid[d]));
            chk("done", d, int'(odn[d]), int'(e_done[d]));
            chk("overflow", d, int'(oov[d]), int'(e_ovf[d]));
            if (e_valid[d]) chk("data", d, int'(od[d]), e_data[d]);
            if (ov[d] && ready && ln[d] < 32) begin
                lg[d][ln[d]] = int'(od[d]);
                ln[d]++;
            end
            if (odn[d]) dn[d]++;
        end
    end

    task automatic step(input logic [2:0] e, input logic signed [47:0] v);
        en = e;
        p  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 48'sd0);
    endtask

    task automatic clr_logs();
        for (int d = 0; d < ND; d++) begin
            ln[d] = 0;
            dn[d] = 0;
        end
    endtask

    task automatic chk_out(input string nm, input int d, input int n);
        chk({nm, "_count"}, d, ln[d], n);
        for (int i = 0; i < n; i++) chk(nm, d, lg[d][i], ex[i]);
    endtask

    localparam logic signed [47:0] T3P [12] = '{48'sh100000, -48'sd1048576, 48'sh7FF0, 48'sd999,
                                                -48'sd17, 48'sh7FFFF, 48'sh80000, 48'sd5,
                                                -48'sd524288, -48'sd524289, 48'sd31, 48'sd7};
`ifdef CONV_OUT_RELU_EN
    localparam int T3E [9] = '{32767, 0, 2047, 0, 32767, 32767, 0, 0, 1};
`else
    localparam int T3E [9] = '{32767, -32768, 2047, -2, 32767, 32767, -32768, -32768, 1};
`endif

    initial begin
        rst   = 1'b1;
        en    = 3'b000;
        p     = 48'sd0;
        ready = 1'b1;
        clr_logs();
        step(3'b111, 48'sd3);
        step(3'b111, 48'sd3);
        for (int d = 0; d < ND; d++) begin
            chk("rst_data", d, int'(od[d]), 0);
            chk("rst_valid", d, int'(ov[d]), 0);
            chk("rst_done", d, int'(odn[d]), 0);
            chk("rst_overflow", d, int'(oov[d]), 0);
        end
        rst = 1'b0;

        // Basic 4x4 / 3x3 frame
        clr_logs();
        for (int i = 0; i < 10; i++) step(3'b001, 48'(i));
        idle(12);
        ex = '{0, 1, 4, 5, 0, 0, 0, 0, 0};
        chk_out("t1_out", 0, 4);
        chk("t1_done_count", 0, dn[0], 1);

        // FM == K: one sample per frame, held in the FIFO until released
        clr_logs();
        ready = 1'b0;
        step(3'b100, -48'sd5);
        for (int i = 1; i < 16; i++) step(3'b100, 48'(i));
        chk("t2_hold_valid", 2, int'(ov[2]), 1);
        chk("t2_hold_done", 2, dn[2], 0);
        ready = 1'b1;
        idle(12);
        ex = '{RELU ? 0 : -3, 0, 0, 0, 0, 0, 0, 0, 0};
        chk_out("t2_out", 2, 1);
        chk("t2_done_count", 2, dn[2], 1);

        // Shift and saturation boundaries, 4x4 / 2x2 frame
        clr_logs();
        for (int i = 0; i < 12; i++) step(3'b010, T3P[i]);
        idle(12);
        for (int i = 0; i < 9; i++) ex[i] = T3E[i];
        chk_out("t3_out", 1, 9);
        chk("t3_done_count", 1, dn[1], 1);
        chk("t3_overflow", 1, int'(oov[1]), 0);

        // Overflow with stalled consumer
        clr_logs();
        ready = 1'b0;
        for (int i = 0; i < 8; i++) step(3'b010, 48'(i * 16 + 16));
        idle(4);
        chk("t4_overflow", 1, int'(oov[1]), 1);
        ready = 1'b1;
        idle(10);
        ex = '{1, 2, 3, 5, 0, 0, 0, 0, 0};
        chk_out("t4_out", 1, 4);
        chk("t4_done_count", 1, dn[1], 0);
        chk("t4_overflow_sticky", 1, int'(oov[1]), 1);

        // Reset mid-frame, then a fresh frame
        for (int i = 0; i < 7; i++) step(3'b001, 48'(100 + i));
        rst = 1'b1;
        step(3'b011, 48'sd77);
        rst = 1'b0;
        clr_logs();
        chk("t5_rst_valid", 0, int'(ov[0]), 0);
        chk("t5_rst_data", 0, int'(od[0]), 0);
        chk("t5_rst_overflow", 1, int'(oov[1]), 0);
        for (int i = 0; i < 10; i++) step(3'b001, 48'(i * 3));
        idle(12);
        ex = '{0, 3, 12, 15, 0, 0, 0, 0, 0};
        chk_out("t5_out", 0, 4);
        chk("t5_done_count", 0, dn[0], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
